kp_note_ctrl: RTL and testbench

Note-event front end for the Karplus-Strong voice. Accepts note events over a valid/ready handshake, buffers them in a 4-entry FIFO, converts note+octave to a delay-line length, and drives the voice's active-low `trig` input with debounce-safe low/high pulse widths. Sits directly upstream of the string-synthesis core, feeding its `delay_length`, `filtsw` and `trig` inputs.

---
 rtl/kp_pkg.sv | 23 ++
 rtl/kp_event_fifo.sv | 46 ++++
 rtl/kp_note_ctrl.sv | 85 ++++++++
 tb/tb_kp_note_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// kp_pkg: shared types, base loop lengths and the note-to-length helper for kp_note_ctrl.
package kp_pkg;

    localparam int NOTE_MAX = 11;

    localparam logic [10:0] BASE_LEN [0:11] = '{
        11'd1468, 11'd1386, 11'd1308, 11'd1234, 11'd1165, 11'd1100,
        11'd1038, 11'd980,  11'd925,  11'd873,  11'd824,  11'd778
    };

    typedef enum logic [1:0] {IDLE, HOLD, GAP} kp_state_e;

    typedef struct packed {
        logic [3:0] note;
        logic [1:0] oct;
        logic [2:0] filt;
    } kp_event_t;

    function automatic logic [10:0] note_len(input logic [3:0] note, input logic [1:0] oct);
        return (note > 4'(NOTE_MAX)) ? 11'd0 : BASE_LEN[note] >> oct;
    endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// kp_event_fifo: 4-deep, 9-bit synchronous FIFO with full/empty flags and async active-low clear.
module kp_event_fifo (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [8:0] din_i,
    input  logic       pop_i,
    output logic [8:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [8:0] mem_q [4];
    logic [1:0] wr_q, wr_d, rd_q, rd_d;
    logic [2:0] cnt_q, cnt_d;
    logic       do_push, do_pop;

    assign full_o  = cnt_q == 3'd4;
    assign empty_o = cnt_q == 3'd0;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = do_push ? wr_q + 2'd1 : wr_q;
        rd_d  = do_pop ? rd_q + 2'd1 : rd_q;
        cnt_d = cnt_q + {2'b0, do_push} - {2'b0, do_pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/kp_note_ctrl.sv
// kp_note_ctrl: note-event front end; queues events and drives delay_length/filtsw/trig_n
// for the Karplus-Strong voice with fixed low/high trigger widths.
module kp_note_ctrl
    import kp_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 8
) (
    input  logic        a_clk,
    input  logic        reset_n,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [3:0]  ev_note,
    input  logic [1:0]  ev_oct,
    input  logic [2:0]  ev_filt,
    output logic [10:0] delay_length,
    output logic [2:0]  filtsw,
    output logic        trig_n,
    output logic        busy,
    output logic        err
);

    kp_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [2:0]  filt_q, filt_d;
    logic        trig_n_q, trig_n_d, err_q, err_d;
    logic        full, empty, push, load, last_hold, last_gap, bad_note;
    logic [8:0]  fifo_dout;
    kp_event_t   head;

    // Invalid notes complete the handshake but never enter the FIFO.
    assign bad_note = ev_note > 4'(NOTE_MAX);
    assign ev_ready = ~full;
    assign push     = ev_valid & ev_ready & ~bad_note;
    assign head     = kp_event_t'(fifo_dout);

    kp_event_fifo u_fifo (
        .clk_i   (a_clk),
        .rst_ni  (reset_n),
        .push_i  (push),
        .din_i   ({ev_note, ev_oct, ev_filt}),
        .pop_i   (load),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        last_hold = (state_q == HOLD) && (cnt_q == 8'(HOLD_CYCLES - 1));
        last_gap  = (state_q == GAP) && (cnt_q == 8'(GAP_CYCLES - 1));
        load      = ~empty && ((state_q == IDLE) || last_gap);
        state_d   = load ? HOLD : last_hold ? GAP : last_gap ? IDLE : state_q;
        cnt_d     = (load || last_hold || state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
        trig_n_d  = load ? 1'b0 : last_hold ? 1'b1 : trig_n_q;
        len_d     = load ? note_len(head.note, head.oct) : len_q;
        filt_d    = load ? head.filt : filt_q;
        err_d     = ev_valid & ev_ready & bad_note;
    end

    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= BASE_LEN[0];
            filt_q   <= '0;
            trig_n_q <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            filt_q   <= filt_d;
            trig_n_q <= trig_n_d;
            err_q    <= err_d;
        end
    end

    assign delay_length = len_q;
    assign filtsw       = filt_q;
    assign trig_n       = trig_n_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE) || ~empty;

endmodule

// File: tb/tb_kp_note_ctrl.sv
// tb_kp_note_ctrl: scoreboard bench; expected loads are queued at issue and checked on each trig_n fall.
module tb_kp_note_ctrl;

    logic        a_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic [3:0]  ev_note = '0;
    logic [1:0]  ev_oct = '0;
    logic [2:0]  ev_filt = '0;
    logic [10:0] delay_length;
    logic [2:0]  filtsw;
    logic        trig_n, busy, err;

    typedef struct {
        int len;
        int filt;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   falls = 0;
    int   last_fall = -1;
    bit   spacing_on = 1'b0;
    logic prev_trig = 1'b1;

    kp_note_ctrl #(.HOLD_CYCLES(8), .GAP_CYCLES(8)) dut (
        .a_clk        (a_clk),
        .reset_n      (reset_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_note      (ev_note),
        .ev_oct       (ev_oct),
        .ev_filt      (ev_filt),
        .delay_length (delay_length),
        .filtsw       (filtsw),
        .trig_n       (trig_n),
        .busy         (busy),
        .err          (err)
    );

    always #5 a_clk = ~a_clk;

    always @(posedge a_clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Monitor: every trig_n fall must match the oldest queued expectation.
    always @(negedge a_clk) begin
        exp_t e;
        if (prev_trig && !trig_n) begin
            falls++;
            chk("trig_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("delay_length", int'(delay_length), e.len);
                chk("filtsw", int'(filtsw), e.filt);
            end
            if (spacing_on && last_fall >= 0) chk("trig_spacing", cyc - last_fall, 16);
            last_fall = cyc;
        end
        prev_trig = trig_n;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int note, input int oct, input int filt, input int len,
                        output int stall, output int err_seen);
        exp_t e;
        ev_valid = 1'b1;
        ev_note  = 4'(note);
        ev_oct   = 2'(oct);
        ev_filt  = 3'(filt);
        stall    = 0;
        while (!ev_ready && stall < 100) begin
            @(negedge a_clk);
            stall++;
        end
        chk("accept_ready", int'(ev_ready), 1);
        if (len >= 0) begin
            e.len  = len;
            e.filt = filt;
            exp_q.push_back(e);
        end
        @(posedge a_clk);
        @(negedge a_clk);
        err_seen = int'(err);
        ev_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge a_clk);
            n++;
        end
        chk("busy_drop", int'(busy), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, es, lo, hi, f0;
        // Reset
        repeat (3) @(negedge a_clk);
        chk("rst_trig_n", int'(trig_n), 1);
        chk("rst_delay", int'(delay_length), 1468);
        chk("rst_filtsw", int'(filtsw), 0);
        chk("rst_ready", int'(ev_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge a_clk);

        // Single event: 873 >> 2 = 218
        send(9, 2, 5, 218, st, es);
        chk("single_err", es, 0);
        chk("single_trig_before", int'(trig_n), 1);
        chk("single_busy", int'(busy), 1);
        @(negedge a_clk);
        chk("single_trig_low", int'(trig_n), 0);
        chk("single_delay", int'(delay_length), 218);
        lo = 0;
        while (!trig_n && lo < 50) begin
            lo++;
            @(negedge a_clk);
        end
        chk("hold_width", lo, 8);
        hi = 0;
        while (busy && hi < 50) begin
            hi++;
            @(negedge a_clk);
        end
        chk("gap_width", hi, 8);
        chk("single_delay_hold", int'(delay_length), 218);

        // Burst behind a leading event: 4 fill the FIFO, the 5th waits for the next pop
        spacing_on = 1'b1;
        last_fall  = -1;
        send(11, 0, 1, 778, st, es);
        send(0, 0, 0, 1468, st, es);
        chk("burst0_stall", st, 0);
        send(1, 0, 1, 1386, st, es);
        send(2, 0, 2, 1308, st, es);
        send(3, 0, 3, 1234, st, es);
        chk("burst_full_ready", int'(ev_ready), 0);
        send(4, 0, 4, 1165, st, es);
        chk("burst5_stall", st, 13);
        wait_idle();
        spacing_on = 1'b0;
        chk("burst_drained", exp_q.size(), 0);
        chk("burst_last_delay", int'(delay_length), 1165);

        // Invalid note: err pulse only
        f0 = falls;
        send(13, 1, 6, -1, st, es);
        chk("invalid_err", es, 1);
        @(negedge a_clk);
        chk("invalid_err_clear", int'(err), 0);
        chk("invalid_busy", int'(busy), 0);
        repeat (20) @(negedge a_clk);
        chk("invalid_no_trig", falls, f0);
        chk("invalid_delay", int'(delay_length), 1165);

        // Push and pop on the same edge at GAP end with count 1
        spacing_on = 1'b1;
        last_fall  = -1;
        send(5, 1, 2, 550, st, es);
        send(7, 0, 3, 980, st, es);
        repeat (15) @(negedge a_clk);
        send(10, 3, 7, 103, st, es);
        chk("pp_stall", st, 0);
        chk("pp_trig_low", int'(trig_n), 0);
        chk("pp_delay", int'(delay_length), 980);
        chk("pp_ready", int'(ev_ready), 1);
        wait_idle();
        spacing_on = 1'b0;
        chk("pp_drained", exp_q.size(), 0);

        // Asynchronous reset mid-HOLD
        send(2, 0, 0, 1308, st, es);
        send(3, 0, 1, 1234, st, es);
        repeat (2) @(negedge a_clk);
        chk("mid_hold_trig", int'(trig_n), 0);
        #1 reset_n = 1'b0;
        #1 chk("async_trig", int'(trig_n), 1);
        chk("async_busy", int'(busy), 0);
        exp_q.delete();
        @(negedge a_clk);
        reset_n = 1'b1;
        f0 = falls;
        repeat (40) @(negedge a_clk);
        chk("post_rst_no_trig", falls, f0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_delay", int'(delay_length), 1468);
        chk("post_rst_ready", int'(ev_ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
